// File: rtl/main_control_pkg.sv
// Shared definitions for the pipelined main control: opcodes, ALU-op encodings
// and the control bundle carried from ID into EX.
`timescale 1ns/1ps
package main_control_pkg;

    localparam int OPCODE_W = 6;
    localparam int REG_W    = 5;
    localparam int ALUOP_W  = 3;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OPCODE_W-1:0] OP_BGTZ  = 6'b000111;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD    = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_BRANCH = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_RTYPE  = 3'b100;

    // Controls that travel down the pipe; an all-zero value is a bubble.
    typedef struct packed {
        logic [ALUOP_W-1:0] aluop;
        logic               reg_dst;
        logic               alu_src;
        logic               beq;
        logic               bne;
        logic               bgtz;
        logic               mem_wr;
        logic               mem_rd;
        logic               reg_wr;
        logic               mem_to_reg;
    } ex_ctrl_t;

    localparam int EX_CTRL_W = $bits(ex_ctrl_t);

    // Instructions whose rt field is a source operand (can hit a load-use hazard on rt).
    function automatic logic op_uses_rt(input logic [OPCODE_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/main_control_if.sv
// Bus between the IF/ID side (master) and the pipelined main control (slave).
`timescale 1ns/1ps
interface main_control_if #(
    parameter int OPW    = 6,
    parameter int REGW   = 5,
    parameter int ALUOPW = 3,
    parameter int CNTW   = 16
);
    logic              id_valid;
    logic [OPW-1:0]    id_opcode;
    logic [REGW-1:0]   id_rs;
    logic [REGW-1:0]   id_rt;
    logic              ex_flush;

    logic              stall;
    logic              id_ExtOp;
    logic              id_Jump;

    logic              ex_valid;
    logic [ALUOPW-1:0] ex_aluop;
    logic              ex_RegDst;
    logic              ex_ALUSrc;
    logic              ex_beq;
    logic              ex_bne;
    logic              ex_bgtz;

    logic              mem_valid;
    logic              mem_MemWr;
    logic              mem_MemRd;

    logic              wb_valid;
    logic              wb_RegWr;
    logic              wb_MemtoReg;

    logic [CNTW-1:0]   stall_cnt;

    modport master (
        output id_valid, id_opcode, id_rs, id_rt, ex_flush,
        input  stall, id_ExtOp, id_Jump,
        input  ex_valid, ex_aluop, ex_RegDst, ex_ALUSrc, ex_beq, ex_bne, ex_bgtz,
        input  mem_valid, mem_MemWr, mem_MemRd,
        input  wb_valid, wb_RegWr, wb_MemtoReg,
        input  stall_cnt
    );

    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt, ex_flush,
        output stall, id_ExtOp, id_Jump,
        output ex_valid, ex_aluop, ex_RegDst, ex_ALUSrc, ex_beq, ex_bne, ex_bgtz,
        output mem_valid, mem_MemWr, mem_MemRd,
        output wb_valid, wb_RegWr, wb_MemtoReg,
        output stall_cnt
    );

endinterface

// File: rtl/main_control_dec.sv
// Combinational opcode -> control bundle decode for the ID stage.
// Optional feature macro: MAIN_CONTROL_JUMP_EN (decodes j to a jump flag).
`timescale 1ns/1ps
module main_control_dec
    import main_control_pkg::*;
(
    input  logic                valid,
    input  logic [OPCODE_W-1:0] opcode,
    output ex_ctrl_t            ctrl,
    output logic                ext_op,
    output logic                jump,
    output logic                uses_rt
);

    // Decode table; an invalid slot or unknown opcode yields an all-zero bundle.
    always_comb begin
        ctrl    = '0;
        ext_op  = 1'b0;
        jump    = 1'b0;
        uses_rt = 1'b0;
        if (valid) begin
            uses_rt = op_uses_rt(opcode);
            case (opcode)
                OP_RTYPE: begin
                    ctrl.aluop   = ALUOP_RTYPE;
                    ctrl.reg_dst = 1'b1;
                    ctrl.reg_wr  = 1'b1;
                end
                OP_LW: begin
                    ctrl.aluop      = ALUOP_ADD;
                    ctrl.alu_src    = 1'b1;
                    ctrl.mem_rd     = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_wr     = 1'b1;
                    ext_op          = 1'b1;
                end
                OP_SW: begin
                    ctrl.aluop   = ALUOP_ADD;
                    ctrl.alu_src = 1'b1;
                    ctrl.mem_wr  = 1'b1;
                    ext_op       = 1'b1;
                end
                OP_BEQ: begin
                    ctrl.aluop = ALUOP_BRANCH;
                    ctrl.beq   = 1'b1;
                end
                OP_BNE: begin
                    ctrl.aluop = ALUOP_BRANCH;
                    ctrl.bne   = 1'b1;
                end
                OP_BGTZ: begin
                    ctrl.aluop = ALUOP_BRANCH;
                    ctrl.bgtz  = 1'b1;
                end
                OP_ADDI: begin
                    ctrl.aluop   = ALUOP_ADD;
                    ctrl.alu_src = 1'b1;
                    ctrl.reg_wr  = 1'b1;
                end
`ifdef MAIN_CONTROL_JUMP_EN
                OP_J: begin
                    jump = 1'b1;
                end
`endif
                default: begin
                    ctrl = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/main_control_pipe.sv
// Pipelined main control: ID decode, ID/EX, EX/MEM and MEM/WB control registers,
// load-use hazard detection with bubble insertion, branch-flush bubbles and a
// saturating stall counter.
// Optional feature macro: MAIN_CONTROL_JUMP_EN (jump decoded and consumed in ID).
`timescale 1ns/1ps
module main_control_pipe
    import main_control_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int REGW   = 5,
    parameter int ALUOPW = 3,
    parameter int CNTW   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    main_control_if.slave bus
);

    logic [OPW-1:0]  id_opcode;
    ex_ctrl_t        dec_ctrl;
    logic            dec_ext_op;
    logic            dec_jump;
    logic            dec_uses_rt;

    logic            load_use;
    logic            stall_int;
    logic            bubble;

    logic            ex_valid_reg,  ex_valid_next;
    ex_ctrl_t        ex_ctrl_reg,   ex_ctrl_next;
    logic [REGW-1:0] ex_rt_reg,     ex_rt_next;

    logic            mem_valid_reg;
    logic            mem_wr_reg;
    logic            mem_rd_reg;
    logic            mem_reg_wr_reg;
    logic            mem_to_reg_reg;

    logic            wb_valid_reg;
    logic            wb_reg_wr_reg;
    logic            wb_to_reg_reg;

    logic [CNTW-1:0] stall_cnt_reg, stall_cnt_next;

    assign id_opcode = bus.id_opcode;

    main_control_dec u_dec (
        .valid   (bus.id_valid),
        .opcode  (id_opcode),
        .ctrl    (dec_ctrl),
        .ext_op  (dec_ext_op),
        .jump    (dec_jump),
        .uses_rt (dec_uses_rt)
    );

    // Load in EX whose destination is read by the ID instruction; $zero never conflicts.
    always_comb begin
        load_use = bus.id_valid && ex_valid_reg && ex_ctrl_reg.mem_rd &&
                   (ex_rt_reg != '0) &&
                   ((ex_rt_reg == bus.id_rs) || ((ex_rt_reg == bus.id_rt) && dec_uses_rt));
        // A flush kills the ID instruction anyway, so it masks the stall.
        stall_int = load_use && !bus.ex_flush;
        // dec_jump is constant 0 unless the jump feature is built in.
        bubble    = stall_int || bus.ex_flush || dec_jump;
    end

    // Next ID/EX contents: the decoded bundle, or a bubble.
    always_comb begin
        ex_valid_next = bus.id_valid && !bubble;
        ex_ctrl_next  = dec_ctrl;
        ex_rt_next    = bus.id_rt;
        if (!ex_valid_next) begin
            ex_ctrl_next = '0;
            ex_rt_next   = '0;
        end
    end

    // Stall counter sticks at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (stall_int && (stall_cnt_reg != '1)) begin
            stall_cnt_next = stall_cnt_reg + CNTW'(1);
        end
    end

    // ID/EX register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_reg <= 1'b0;
            ex_ctrl_reg  <= '0;
            ex_rt_reg    <= '0;
        end else begin
            ex_valid_reg <= ex_valid_next;
            ex_ctrl_reg  <= ex_ctrl_next;
            ex_rt_reg    <= ex_rt_next;
        end
    end

    // EX/MEM register: always advances, even while ID is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid_reg  <= 1'b0;
            mem_wr_reg     <= 1'b0;
            mem_rd_reg     <= 1'b0;
            mem_reg_wr_reg <= 1'b0;
            mem_to_reg_reg <= 1'b0;
        end else begin
            mem_valid_reg  <= ex_valid_reg;
            mem_wr_reg     <= ex_ctrl_reg.mem_wr;
            mem_rd_reg     <= ex_ctrl_reg.mem_rd;
            mem_reg_wr_reg <= ex_ctrl_reg.reg_wr;
            mem_to_reg_reg <= ex_ctrl_reg.mem_to_reg;
        end
    end

    // MEM/WB register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid_reg  <= 1'b0;
            wb_reg_wr_reg <= 1'b0;
            wb_to_reg_reg <= 1'b0;
        end else begin
            wb_valid_reg  <= mem_valid_reg;
            wb_reg_wr_reg <= mem_reg_wr_reg;
            wb_to_reg_reg <= mem_to_reg_reg;
        end
    end

    // Stall-cycle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign bus.stall    = stall_int;
    assign bus.id_ExtOp = dec_ext_op;
`ifdef MAIN_CONTROL_JUMP_EN
    assign bus.id_Jump  = dec_jump && !bus.ex_flush;
`else
    assign bus.id_Jump  = 1'b0;
`endif

    assign bus.ex_valid    = ex_valid_reg;
    assign bus.ex_aluop    = ALUOPW'(ex_ctrl_reg.aluop);
    assign bus.ex_RegDst   = ex_ctrl_reg.reg_dst;
    assign bus.ex_ALUSrc   = ex_ctrl_reg.alu_src;
    assign bus.ex_beq      = ex_ctrl_reg.beq;
    assign bus.ex_bne      = ex_ctrl_reg.bne;
    assign bus.ex_bgtz     = ex_ctrl_reg.bgtz;

    assign bus.mem_valid   = mem_valid_reg;
    assign bus.mem_MemWr   = mem_wr_reg;
    assign bus.mem_MemRd   = mem_rd_reg;

    assign bus.wb_valid    = wb_valid_reg;
    assign bus.wb_RegWr    = wb_reg_wr_reg;
    assign bus.wb_MemtoReg = wb_to_reg_reg;

    assign bus.stall_cnt   = stall_cnt_reg;

endmodule

// File: tb/tb_main_control_pipe.sv
// Scoreboard bench for main_control_pipe: directed instruction stream with
// hand-computed expected controls; a second instance with a 2-bit counter
// sees the same stream to exercise saturation.
`timescale 1ns/1ps
module tb_main_control_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    main_control_if #(.CNTW(16)) bus ();
    main_control_if #(.CNTW(2))  bus_s ();

    assign bus_s.id_valid  = bus.id_valid;
    assign bus_s.id_opcode = bus.id_opcode;
    assign bus_s.id_rs     = bus.id_rs;
    assign bus_s.id_rt     = bus.id_rt;
    assign bus_s.ex_flush  = bus.ex_flush;

    main_control_pipe #(.OPW(6), .REGW(5), .ALUOPW(3), .CNTW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    main_control_pipe #(.OPW(6), .REGW(5), .ALUOPW(3), .CNTW(2)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    // Expected-value bundles: ex word = {valid, aluop[2:0], RegDst, ALUSrc, beq, bne, bgtz}
    localparam logic [8:0] E_ADDI = 9'b1_000_0_1_000;
    localparam logic [8:0] E_R    = 9'b1_100_1_0_000;
    localparam logic [8:0] E_LW   = 9'b1_000_0_1_000;
    localparam logic [8:0] E_SW   = 9'b1_000_0_1_000;
    localparam logic [8:0] E_BEQ  = 9'b1_001_0_0_100;
    localparam logic [8:0] E_BNE  = 9'b1_001_0_0_010;
    localparam logic [8:0] E_BGTZ = 9'b1_001_0_0_001;
    localparam logic [8:0] E_NOPV = 9'b1_000_0_0_000;
    localparam logic [8:0] E_BUB  = 9'b0;
    // mem word = {valid, MemWr, MemRd}
    localparam logic [2:0] M_V    = 3'b100;
    localparam logic [2:0] M_LW   = 3'b101;
    localparam logic [2:0] M_SW   = 3'b110;
    localparam logic [2:0] M_BUB  = 3'b000;

    typedef struct {
        int          due;
        int          sel;
        logic [15:0] exp;
        string       name;
    } exp_t;

    typedef struct {
        logic [1:0] exp;
        string      name;
    } wb_t;

    exp_t tq[$];
    wb_t  wq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", name, act, cyc);
        end
    endtask

    function automatic logic [15:0] sample(input int sel);
        case (sel)
            0: return {13'b0, bus.stall, bus.id_ExtOp, bus.id_Jump};
            1: return {7'b0, bus.ex_valid, bus.ex_aluop, bus.ex_RegDst, bus.ex_ALUSrc,
                       bus.ex_beq, bus.ex_bne, bus.ex_bgtz};
            2: return {13'b0, bus.mem_valid, bus.mem_MemWr, bus.mem_MemRd};
            3: return bus.stall_cnt;
            default: return {14'b0, bus_s.stall_cnt};
        endcase
    endfunction

    // Monitor: mid-cycle, compare every timed expectation that is due and pop the
    // write-back queue whenever the DUT presents a valid MEM/WB slot.
    always @(negedge clk) begin
        wb_t w;
        if (rst_n) begin
            for (int i = tq.size() - 1; i >= 0; i--) begin
                if (tq[i].due == cyc) begin
                    check(tq[i].name, sample(tq[i].sel), tq[i].exp);
                    tq.delete(i);
                end
            end
            if (bus.wb_valid) begin
                if (wq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wb_unexpected: got wb_valid=1 with nothing outstanding (cycle %0d)", cyc);
                end else begin
                    w = wq.pop_front();
                    check({w.name, "_wb"}, {14'b0, bus.wb_RegWr, bus.wb_MemtoReg}, {14'b0, w.exp});
                end
            end
        end
    end

    // Present one ID-stage instruction and queue everything it should produce.
    task automatic issue(input logic v, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic fl, input logic [2:0] comb,
                         input logic [8:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                         input int cnt, input string name);
        int sat;
        @(posedge clk);
        #1;
        bus.id_valid  = v;
        bus.id_opcode = op;
        bus.id_rs     = rs;
        bus.id_rt     = rt;
        bus.ex_flush  = fl;
        sat = (cnt > 3) ? 3 : cnt;
        tq.push_back('{cyc,     0, {13'b0, comb}, {name, "_id"}});
        tq.push_back('{cyc + 1, 1, {7'b0, ex},    {name, "_ex"}});
        tq.push_back('{cyc + 2, 2, {13'b0, mem},  {name, "_mem"}});
        tq.push_back('{cyc + 1, 3, 16'(cnt),      {name, "_cnt"}});
        tq.push_back('{cyc + 1, 4, 16'(sat),      {name, "_cntsat"}});
        if (ex[8]) wq.push_back('{wb, name});
    endtask

    task automatic idle(input int cnt, input string name);
        issue(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0, 3'b000, E_BUB, M_BUB, 2'b00, cnt, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] j_comb;
        logic [8:0] j_ex;
        logic [2:0] j_mem;

        bus.id_valid  = 1'b0;
        bus.id_opcode = '0;
        bus.id_rs     = '0;
        bus.id_rt     = '0;
        bus.ex_flush  = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state.
        @(negedge clk);
        check("reset_ex",  sample(1), 16'h0);
        check("reset_mem", sample(2), 16'h0);
        check("reset_wb",  {13'b0, bus.wb_valid, bus.wb_RegWr, bus.wb_MemtoReg}, 16'h0);
        check("reset_cnt", sample(3), 16'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Throughput and decode.
        issue(1, 6'b001000, 5'd1,  5'd2,  0, 3'b000, E_ADDI, M_V,   2'b10, 0, "addi");
        issue(1, 6'b000000, 5'd3,  5'd4,  0, 3'b000, E_R,    M_V,   2'b10, 0, "rtype");
        // Load-use on rs: one stall, bubble, then the held instruction goes.
        issue(1, 6'b100011, 5'd1,  5'd5,  0, 3'b010, E_LW,   M_LW,  2'b11, 0, "lw_rt5");
        issue(1, 6'b000000, 5'd5,  5'd6,  0, 3'b100, E_BUB,  M_BUB, 2'b00, 1, "lu_stall");
        issue(1, 6'b000000, 5'd5,  5'd6,  0, 3'b000, E_R,    M_V,   2'b10, 1, "lu_retry");
        // Load to $zero never stalls.
        issue(1, 6'b100011, 5'd1,  5'd0,  0, 3'b010, E_LW,   M_LW,  2'b11, 1, "lw_rt0");
        issue(1, 6'b000000, 5'd0,  5'd0,  0, 3'b000, E_R,    M_V,   2'b10, 1, "lu_rt0");
        // sw reads rt: stall on rt match.
        issue(1, 6'b100011, 5'd2,  5'd7,  0, 3'b010, E_LW,   M_LW,  2'b11, 1, "lw_rt7");
        issue(1, 6'b101011, 5'd1,  5'd7,  0, 3'b110, E_BUB,  M_BUB, 2'b00, 2, "sw_stall");
        issue(1, 6'b101011, 5'd1,  5'd7,  0, 3'b010, E_SW,   M_SW,  2'b00, 2, "sw_retry");
        // addi does not read rt: rt match alone must not stall.
        issue(1, 6'b100011, 5'd2,  5'd8,  0, 3'b010, E_LW,   M_LW,  2'b11, 2, "lw_rt8");
        issue(1, 6'b001000, 5'd9,  5'd8,  0, 3'b000, E_ADDI, M_V,   2'b10, 2, "addi_rt_nouse");
        // Flush collides with load-use: bubble only, no stall, counter unchanged.
        issue(1, 6'b100011, 5'd1,  5'd3,  0, 3'b010, E_LW,   M_LW,  2'b11, 2, "lw_rt3");
        issue(1, 6'b001000, 5'd3,  5'd1,  1, 3'b000, E_BUB,  M_BUB, 2'b00, 2, "flush_collide");
        // Branches and an illegal opcode.
        issue(1, 6'b000100, 5'd1,  5'd2,  0, 3'b000, E_BEQ,  M_V,   2'b00, 2, "beq");
        issue(1, 6'b000101, 5'd1,  5'd2,  0, 3'b000, E_BNE,  M_V,   2'b00, 2, "bne");
        issue(1, 6'b000111, 5'd1,  5'd2,  0, 3'b000, E_BGTZ, M_V,   2'b00, 2, "bgtz");
        issue(1, 6'b111111, 5'd0,  5'd0,  0, 3'b000, E_NOPV, M_V,   2'b00, 2, "illegal");
`ifdef MAIN_CONTROL_JUMP_EN
        j_comb = 3'b001; j_ex = E_BUB;  j_mem = M_BUB;
`else
        j_comb = 3'b000; j_ex = E_NOPV; j_mem = M_V;
`endif
        issue(1, 6'b000010, 5'd0,  5'd0,  0, j_comb, j_ex,   j_mem, 2'b00, 2, "jump");
        idle(2, "idle0");
        // Branch reads rt: stall on rt match.
        issue(1, 6'b100011, 5'd4,  5'd10, 0, 3'b010, E_LW,   M_LW,  2'b11, 2, "lw_rt10");
        issue(1, 6'b000100, 5'd1,  5'd10, 0, 3'b100, E_BUB,  M_BUB, 2'b00, 3, "beq_stall");
        issue(1, 6'b000100, 5'd1,  5'd10, 0, 3'b000, E_BEQ,  M_V,   2'b00, 3, "beq_retry");
        // No instruction in ID: no stall.
        issue(1, 6'b100011, 5'd1,  5'd11, 0, 3'b010, E_LW,   M_LW,  2'b11, 3, "lw_rt11");
        issue(0, 6'b000000, 5'd11, 5'd11, 0, 3'b000, E_BUB,  M_BUB, 2'b00, 3, "lu_idle");
        // Two more stalls: the 2-bit counter holds at 3.
        issue(1, 6'b100011, 5'd1,  5'd12, 0, 3'b010, E_LW,   M_LW,  2'b11, 3, "lw_rt12");
        issue(1, 6'b000000, 5'd12, 5'd1,  0, 3'b100, E_BUB,  M_BUB, 2'b00, 4, "r_stall");
        issue(1, 6'b000000, 5'd12, 5'd1,  0, 3'b000, E_R,    M_V,   2'b10, 4, "r_retry");
        issue(1, 6'b100011, 5'd1,  5'd13, 0, 3'b010, E_LW,   M_LW,  2'b11, 4, "lw_rt13");
        issue(1, 6'b001000, 5'd13, 5'd2,  0, 3'b100, E_BUB,  M_BUB, 2'b00, 5, "addi_stall");
        issue(1, 6'b001000, 5'd13, 5'd2,  0, 3'b000, E_ADDI, M_V,   2'b10, 5, "addi_retry");
        for (int i = 0; i < 4; i++) idle(5, "drain");
        repeat (3) @(posedge clk);

        // Asynchronous reset in the middle of a stall.
        @(posedge clk); #1;
        bus.id_valid = 1'b1; bus.id_opcode = 6'b100011; bus.id_rs = 5'd1; bus.id_rt = 5'd14;
        @(posedge clk); #1;
        bus.id_opcode = 6'b000000; bus.id_rs = 5'd14; bus.id_rt = 5'd2;
        #1;
        check("pre_reset_stall", sample(0), 16'h4);
        rst_n = 1'b0;
        #1;
        check("async_rst_ex",     sample(1), 16'h0);
        check("async_rst_mem",    sample(2), 16'h0);
        check("async_rst_wb",     {13'b0, bus.wb_valid, bus.wb_RegWr, bus.wb_MemtoReg}, 16'h0);
        check("async_rst_cnt",    sample(3), 16'h0);
        check("async_rst_cntsat", sample(4), 16'h0);
        check("async_rst_stall",  sample(0), 16'h0);
        bus.id_valid = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Pipeline runs normally after reset.
        issue(1, 6'b001000, 5'd1,  5'd2,  0, 3'b000, E_ADDI, M_V,   2'b10, 0, "post_rst_addi");
        for (int i = 0; i < 4; i++) idle(0, "post_drain");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("tq_empty", 16'(tq.size()), 16'h0);
        check("wq_empty", 16'(wq.size()), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
